// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl
//   Drives the ChaCha20 core's init/next/ready request interface for a
//   message made of 512-bit blocks. One block is in flight at a time:
//   accept from upstream, issue to the core, wait for the XORed result,
//   hold it for downstream, then either take the next block or finish.
//   Encryption and decryption are the same operation.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   start, key_in, iv_in,      begin a message; key/nonce/first counter are
//   ctr_base                   latched when start is seen in IDLE
//   in_valid/in_ready/in_data/ upstream block stream
//   in_last
//   out_valid/out_ready/       downstream result stream; out_last mirrors the
//   out_data/out_last          in_last of the same block
//   core_init/core_next/       request to the core, held until core_ready
//   core_ready
//   core_key/ctr/iv/data_in    operands to the core, stable from issue until
//                              the result strobe
//   core_data_out_valid/       1-cycle result strobe and data from the core
//   core_data_out
//   busy, done, ctr_wrap,      status: not idle, end-of-message pulse,
//   blk_count                  sticky counter wrap, blocks delivered

module chacha_stream_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             start,
    input  logic [255:0]     key_in,
    input  logic [63:0]      iv_in,
    input  logic [63:0]      ctr_base,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_data,
    input  logic             in_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     out_data,
    output logic             out_last,

    output logic             core_init,
    output logic             core_next,
    output logic [255:0]     core_key,
    output logic [63:0]      core_ctr,
    output logic [63:0]      core_iv,
    output logic [511:0]     core_data_in,
    input  logic             core_ready,
    input  logic             core_data_out_valid,
    input  logic [511:0]     core_data_out,

    output logic             busy,
    output logic             done,
    output logic             ctr_wrap,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic [255:0]       key_q, key_d;
    logic [63:0]        ctr_q, ctr_d;
    logic [63:0]        iv_q, iv_d;
    logic [511:0]       data_q, data_d;
    logic               out_valid_q, out_valid_d;
    logic [511:0]       out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   blk_q, blk_d;

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        key_d       = key_q;
        ctr_d       = ctr_q;
        iv_d        = iv_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        wrap_d      = wrap_q;
        blk_d       = blk_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    iv_d    = iv_in;
                    ctr_d   = ctr_base;
                    first_d = 1'b1;
                    wrap_d  = 1'b0;
                    blk_d   = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter advances on the result strobe, not at issue,
                // so the core sees a stable counter for the whole request.
                if (core_data_out_valid) begin
                    out_data_d  = core_data_out;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    first_d     = 1'b0;
                    ctr_d       = ctr_q + 64'd1;
                    if (&ctr_q) begin
                        wrap_d = 1'b1;
                    end
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_d       = blk_q + CNT_W'(1);
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            key_q       <= '0;
            ctr_q       <= '0;
            iv_q        <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            last_q      <= last_d;
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            iv_q        <= iv_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            blk_q       <= blk_d;
        end
    end

    // Handshake qualifiers depend on state only, so start arriving with
    // in_valid in IDLE can never be taken as a block.
    assign in_ready     = (state_q == S_ACCEPT);
    assign core_init    = (state_q == S_ISSUE) &&  first_q;
    assign core_next    = (state_q == S_ISSUE) && !first_q;
    assign busy         = (state_q != S_IDLE);

    assign core_key     = key_q;
    assign core_ctr     = ctr_q;
    assign core_iv      = iv_q;
    assign core_data_in = data_q;

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign done         = done_q;
    assign ctr_wrap     = wrap_q;
    assign blk_count    = blk_q;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl. A behavioural core stub answers requests
// two cycles after transfer with data_in XOR a keystream-like mix of
// key/ctr/iv. Stimulus pushes expected requests and results into queues;
// the core stub and an output monitor pop and compare.

module tb_chacha_stream_ctrl;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [255:0]   key_in;
    logic [63:0]    iv_in;
    logic [63:0]    ctr_base;
    logic           in_valid;
    logic           in_ready;
    logic [511:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_data;
    logic           out_last;
    logic           core_init;
    logic           core_next;
    logic [255:0]   core_key;
    logic [63:0]    core_ctr;
    logic [63:0]    core_iv;
    logic [511:0]   core_data_in;
    logic           core_ready;
    logic           core_data_out_valid;
    logic [511:0]   core_data_out;
    logic           busy;
    logic           done;
    logic           ctr_wrap;
    logic [31:0]    blk_count;

    chacha_stream_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in),
        .iv_in(iv_in), .ctr_base(ctr_base), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .core_init(core_init), .core_next(core_next),
        .core_key(core_key), .core_ctr(core_ctr), .core_iv(core_iv),
        .core_data_in(core_data_in), .core_ready(core_ready),
        .core_data_out_valid(core_data_out_valid),
        .core_data_out(core_data_out), .busy(busy), .done(done),
        .ctr_wrap(ctr_wrap), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Keystream stand-in for the core.
    function automatic logic [511:0] ks(input logic [255:0] k, input logic [63:0] c,
                                        input logic [63:0] n);
        logic [511:0] r;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            w = k[32*(i%8) +: 32] ^ (c[31:0] * 32'(2*i+1)) ^ c[63:32]
                ^ (n[31:0] + 32'(i)) ^ n[63:32] ^ (32'h9E3779B9 * 32'(i+1));
            w = {w[24:0], w[31:25]} + w;
            r[32*i +: 32] = w;
        end
        return r;
    endfunction

    typedef struct {
        logic         init;
        logic [63:0]  ctr;
        logic [255:0] key;
        logic [63:0]  iv;
        logic [511:0] data;
    } req_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
        int           blk;
    } out_t;

    req_t req_q[$];
    out_t exp_q[$];

    // Message context tracked by the bench
    logic [255:0] tb_key;
    logic [63:0]  tb_iv;
    logic [63:0]  tb_ctr;
    int           tb_blk;
    int           hs_cyc;
    int           stall_left = 0;

    // ---------------- core stub ----------------
    logic         xfer;
    logic         resp_pend;
    logic         inflight;
    logic         stall_seen;
    logic [511:0] stall_snap;
    req_t         cap;

    initial begin
        core_ready = 1'b0;
        core_data_out_valid = 1'b0;
        core_data_out = '0;
        resp_pend = 1'b0;
        inflight = 1'b0;
        stall_seen = 1'b0;
        stall_snap = '0;
        forever begin
            @(negedge clk);
            xfer = reset_n && (core_init || core_next) && core_ready;
            if (reset_n && inflight) begin
                chk("stable_ctr", {448'd0, core_ctr}, {448'd0, cap.ctr});
                chk("stable_data", core_data_in, cap.data);
                chk("stable_keyiv", {192'd0, core_key, core_iv}, {192'd0, cap.key, cap.iv});
            end
            if (reset_n && stall_seen && !core_ready) begin
                chk("stall_init_held", {511'd0, core_init}, 512'd1);
                chk("stall_data_stable", core_data_in, stall_snap);
            end
            if (xfer) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 512'd1, 512'd0);
                end else begin
                    cap = req_q.pop_front();
                    chk("req_init", {510'd0, core_init, core_next}, {510'd0, cap.init, !cap.init});
                    chk("req_ctr", {448'd0, core_ctr}, {448'd0, cap.ctr});
                    chk("req_key", {256'd0, core_key}, {256'd0, cap.key});
                    chk("req_iv", {448'd0, core_iv}, {448'd0, cap.iv});
                    chk("req_data", core_data_in, cap.data);
                end
            end
            @(posedge clk);
            #1;
            core_data_out_valid = 1'b0;
            if (!reset_n) begin
                resp_pend = 1'b0;
                inflight = 1'b0;
                stall_seen = 1'b0;
                core_ready = 1'b0;
                continue;
            end
            if (xfer) begin
                resp_pend = 1'b1;
                inflight = 1'b1;
            end else if (resp_pend) begin
                resp_pend = 1'b0;
                core_data_out_valid = 1'b1;
                core_data_out = cap.data ^ ks(cap.key, cap.ctr, cap.iv);
            end else begin
                inflight = 1'b0;
            end
            core_ready = !resp_pend;
            if (stall_left > 0 && (core_init || core_next)) begin
                if (!stall_seen) stall_snap = core_data_in;
                stall_seen = 1'b1;
                core_ready = 1'b0;
                stall_left--;
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic chk_after = 1'b0;
    logic pend_done;
    int   pend_blk;

    always @(negedge clk) begin
        out_t e;
        if (chk_after) begin
            chk("done_pulse", {511'd0, done}, {511'd0, pend_done});
            chk("blk_count", {480'd0, blk_count}, {480'd0, 32'(pend_blk)});
            chk_after = 1'b0;
        end
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 512'd1, 512'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", {511'd0, out_last}, {511'd0, e.last});
                pend_done = e.last;
                pend_blk = e.blk;
                chk_after = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_msg(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
        @(posedge clk); #1;
        start = 1'b1; key_in = k; iv_in = n; ctr_base = c;
        @(posedge clk); #1;
        start = 1'b0;
        tb_key = k; tb_iv = n; tb_ctr = c; tb_blk = 0;
    endtask

    task automatic send_block(input logic [511:0] pt, input logic last,
                              input logic use_exp, input logic [511:0] exp);
        req_t r;
        out_t o;
        bit   ok;
        r.init = (tb_blk == 0); r.ctr = tb_ctr; r.key = tb_key; r.iv = tb_iv; r.data = pt;
        req_q.push_back(r);
        o.data = use_exp ? exp : (pt ^ ks(tb_key, tb_ctr, tb_iv));
        o.last = last;
        o.blk = tb_blk + 1;
        exp_q.push_back(o);
        tb_ctr = tb_ctr + 64'd1;
        tb_blk++;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = pt; in_last = last;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("in_handshake_timeout", 512'd1, 512'd0);
        hs_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !chk_after) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 512'd1, 512'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {504'd0, in_ready, out_valid, out_last, core_init, core_next,
                           busy, done, ctr_wrap}, 512'd0);
        chk({nm, "_blk"}, {480'd0, blk_count}, 512'd0);
        chk({nm, "_out_data"}, out_data, 512'd0);
        chk({nm, "_core_kci"}, {128'd0, core_key, core_ctr, core_iv}, 512'd0);
        chk({nm, "_core_data"}, core_data_in, 512'd0);
    endtask

    logic [255:0] key_a;
    logic [511:0] pt [3];
    logic [511:0] ct [3];
    logic [511:0] snap;
    bit           ok;

    initial begin
        reset_n = 1'b0; start = 1'b0; key_in = '0; iv_in = '0; ctr_base = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        tb_key = '0; tb_iv = '0; tb_ctr = '0; tb_blk = 0; hs_cyc = 0;
        for (int i = 0; i < 32; i++) key_a[8*i +: 8] = 8'(i);

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single-block message
        start_msg(key_a, 64'd0, 64'd1);
        send_block(512'd0, 1'b1, 1'b0, 512'd0);
        wait_idle();

        // Three-block message, then feed the ciphertext back
        for (int i = 0; i < 3; i++) begin
            pt[i] = {16{32'hA5A5_0000 + 32'(i)}} ^ {8{64'(i) << (8*i)}};
            ct[i] = pt[i] ^ ks(key_a, 64'd5 + 64'(i), 64'h0123_4567_89AB_CDEF);
        end
        start_msg(key_a, 64'h0123_4567_89AB_CDEF, 64'd5);
        for (int i = 0; i < 3; i++) send_block(pt[i], i == 2, 1'b1, ct[i]);
        wait_idle();
        start_msg(key_a, 64'h0123_4567_89AB_CDEF, 64'd5);
        for (int i = 0; i < 3; i++) send_block(ct[i], i == 2, 1'b1, pt[i]);
        wait_idle();

        // Latency with out_ready held high
        start_msg(~key_a, 64'hDEAD, 64'd100);
        send_block({16{32'h1357_9BDF}}, 1'b0, 1'b0, 512'd0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        chk("lat_out_valid", 512'(ok ? cyc - hs_cyc : -1), 512'd4);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("lat_in_ready", 512'(ok ? cyc - hs_cyc : -1), 512'd5);
        send_block({16{32'h2468_ACE0}}, 1'b1, 1'b0, 512'd0);
        wait_idle();

        // Output backpressure
        start_msg(key_a ^ {8{32'h0F0F_0F0F}}, 64'd7, 64'd9);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_block({8{64'hFEDC_BA98_7654_3210}}, 1'b1, 1'b0, 512'd0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("bp_out_valid_timeout", 512'd1, 512'd0);
        snap = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {508'd0, out_valid, in_ready, core_init, core_next}, {508'd0, 4'b1000});
            chk("bp_data", out_data, snap);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();

        // Counter wrap across two blocks
        start_msg(key_a, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF);
        send_block({16{32'h0BAD_F00D}}, 1'b0, 1'b0, 512'd0);
        send_block({16{32'hC0FF_EE00}}, 1'b1, 1'b0, 512'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("wrap_sticky", {511'd0, ctr_wrap}, 512'd1);

        // Core stall for 3 cycles; the new start clears ctr_wrap
        start_msg(key_a, 64'h66, 64'd42);
        @(negedge clk);
        chk("wrap_cleared", {511'd0, ctr_wrap}, 512'd0);
        stall_left = 3;
        send_block({16{32'h7777_1111}}, 1'b1, 1'b0, 512'd0);
        wait_idle();

        // Reset while waiting on the core
        start_msg(key_a, 64'h77, 64'd3);
        send_block({16{32'h4242_4242}}, 1'b0, 1'b0, 512'd0);
        @(posedge clk); #1;
        exp_q.delete();
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("midrst");
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        start_msg(key_a, 64'h88, 64'd11);
        send_block({16{32'h9999_0000}}, 1'b0, 1'b0, 512'd0);
        send_block({16{32'h0000_9999}}, 1'b1, 1'b0, 512'd0);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("queues_empty", 512'(req_q.size() + exp_q.size()), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
- Initiator for the ChaCha20 cipher core's init/next/ready request interface.
- Accepts a message as a sequence of 512-bit blocks over valid/ready and issues one core request per block: core_init for the first block, core_next for later ones, with an auto-incrementing 64-bit block counter.
- Captures each XORed result and presents it downstream over valid/ready.
- Sits between the memory-side block buffer and the cipher core. Encryption and decryption are the same operation.

Parameters:
CNT_W, 32, width of blk_count (blocks completed in current message)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse, begins new message; sampled only in IDLE
key_in  in  256  key, latched on start
iv_in  in  64  nonce, latched on start
ctr_base  in  64  first block counter, latched on start
in_valid  in  1  upstream block valid
in_ready  out  1  upstream block accepted when in_valid&&in_ready
in_data  in  512  plaintext/ciphertext block
in_last  in  1  final block of message
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  512  result block
out_last  out  1  copy of in_last for this block
core_init  out  1  request, first block
core_next  out  1  request, subsequent blocks
core_key  out  256  to core
core_ctr  out  64  to core
core_iv  out  64  to core
core_data_in  out  512  to core
core_ready  in  1  core idle
core_data_out_valid  in  1  core result strobe (1-cycle)
core_data_out  in  512  core result
busy  out  1  state != IDLE
done  out  1  1-cycle pulse after last block leaves
ctr_wrap  out  1  sticky: counter wrapped in this message
blk_count  out  CNT_W  blocks delivered in this message

Behaviour:
- Reset (async, reset_n=0): all outputs 0 (in_ready, out_valid, out_data, out_last, core_init, core_next, core_key/ctr/iv/data_in, busy, done, ctr_wrap, blk_count). FSM goes to IDLE. A request in flight is dropped; the core is reset by the same reset_n.
- FSM states: IDLE, ACCEPT, ISSUE, WAIT, DRAIN.
- IDLE:
  - start=1: latch key_in→core_key, iv_in→core_iv, ctr_base→core_ctr; first=1; clear ctr_wrap and blk_count; go to ACCEPT.
  - start=0: stay. start is ignored in all other states.
- ACCEPT:
  - in_ready=1 (combinational from state only).
  - On handshake: latch in_data→core_data_in and in_last→last_r; go to ISSUE.
- ISSUE:
  - core_init=first, core_next=!first (combinational from state).
  - Held high until core_ready=1; the request transfers in that cycle. Then go to WAIT.
- WAIT:
  - Requests deasserted.
  - On core_data_out_valid: out_data←core_data_out, out_last←last_r, out_valid←1, first←0.
  - Same edge: core_ctr←core_ctr+1 (mod 2^64). If core_ctr was 64'hFFFF_FFFF_FFFF_FFFF, set ctr_wrap.
  - Go to DRAIN.
- DRAIN:
  - out_valid held and out_data/out_last stable until out_ready.
  - On transfer: out_valid←0, blk_count←blk_count+1 (wraps mod 2^CNT_W).
  - If last_r: go to IDLE and pulse done next cycle. Else go to ACCEPT.
- Stability rule: core_key, core_ctr, core_iv and core_data_in are unchanged from the ISSUE cycle through the core_data_out_valid cycle. The core XORs core_data_in combinationally at response time.
- Latency, with core_ready=1 and out_ready=1:
  - Input handshake at cycle T: ISSUE at T+1, core_data_out_valid at T+3, out_valid at T+4, in_ready again at T+5.
  - One block in flight; throughput is 1 block per 5 cycles.
- Simultaneous events:
  - core_data_out_valid outside WAIT is ignored.
  - start together with in_valid in IDLE: only start acts; in_ready is 0 that cycle.
- Empty message is not supported. A message ends only on an in_last block.

Test Plan:
- Single-block roundtrip: key=0x00..1F bytes, iv=0, ctr_base=1, in_data=0, in_last=1, real core. Required: out_data equals the golden keystream, core_init pulses once, core_ctr=1 at issue, done pulses 1 cycle after the out handshake, blk_count=1.
- Three-block message, ctr_base=5. Required:
  - core_init on block 0 and core_next on blocks 1 and 2.
  - core_ctr=5,6,7 at each issue.
  - out_last only on block 2.
  - Feeding the ciphertext back with the same key/iv/ctr_base reproduces the plaintext exactly.
- Latency: in handshake at cycle T → out_valid rises at T+4 and in_ready rises at T+5 with out_ready tied high.
- Backpressure: out_ready=0 for 10 cycles in DRAIN. Required: out_valid stays 1, out_data is unchanged, in_ready=0, no core request.
- Core stall and wrap:
  - Stub core holds core_ready=0 for 3 cycles. Required: core_init stays high and core_data_in is stable.
  - ctr_base=64'hFFFF_FFFF_FFFF_FFFF, 2 blocks. Required: second issue has core_ctr=0 and ctr_wrap=1 until the next start.
- Reset mid-WAIT: drop reset_n for 2 cycles. Required: all outputs 0, busy=0. A new start then completes normally.
